// File: rtl/receive_engine_if.sv
// Host-side bundle of the UART receive engine: serial input, frame configuration,
// read strobe and the received byte with its status flags.
interface receive_engine_if;
   logic        rx;
   logic        eight;
   logic        pen;
   logic        ohel;
   logic [18:0] k;
   logic        clr;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        perr;
   logic        ferr;
   logic        ovf;

   modport master (
      output rx, eight, pen, ohel, k, clr,
      input  rx_data, rx_rdy, perr, ferr, ovf
   );

   modport slave (
      input  rx, eight, pen, ohel, k, clr,
      output rx_data, rx_rdy, perr, ferr, ovf
   );
endinterface

// File: rtl/receive_engine.sv
// UART receive engine: synchronizes rx, qualifies the start bit at half a bit time,
// samples data/parity/stop at mid-bit and reports the byte with parity/framing/overrun status.
module receive_engine #(
   parameter int SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   receive_engine_if.slave bus
);

   typedef enum logic [1:0] {IDLE, START, DATA} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [18:0]            bt_q, bt_d;
   logic [3:0]             bc_q, bc_d;
   logic [9:0]             sr_q, sr_d;
   logic                   eight_q, eight_d;
   logic                   pen_q, pen_d;
   logic                   ohel_q, ohel_d;
   logic                   done_q, done_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_rdy_q, rx_rdy_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovf_q, ovf_d;

   logic                   rxs;
   logic [18:0]            half_k;
   logic [3:0]             n_bits;
   logic [9:0]             aligned;
   logic [7:0]             data;
   logic                   par_bit;
   logic                   stop_bit;

   assign rxs    = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.rx};
   assign half_k = bus.k >> 1;

   // Frame bits after the start bit, stop included; the shift register fills from
   // bit 9 downward, so the frame sits in the top n_bits positions.
   assign n_bits   = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
   assign aligned  = sr_q >> (4'd10 - n_bits);
   assign data     = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
   assign par_bit  = eight_q ? aligned[8] : aligned[7];
   assign stop_bit = aligned[n_bits - 4'd1];

   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      bt_d      = bt_q;
      bc_d      = bc_q;
      sr_d      = sr_q;
      eight_d   = eight_q;
      pen_d     = pen_q;
      ohel_d    = ohel_q;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      rx_rdy_d  = rx_rdy_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovf_d     = ovf_q;

      case (state_q)
         IDLE: begin
            bt_d = '0;
            if (!rxs) state_d = START;
         end
         START: begin
            if (bt_q == half_k) begin
               bt_d = '0;
               if (!rxs) begin
                  state_d = DATA;
                  bc_d    = '0;
                  eight_d = bus.eight;
                  pen_d   = bus.pen;
                  ohel_d  = bus.ohel;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bt_d = bt_q + 19'd1;
            end
         end
         DATA: begin
            if (bt_q == bus.k) begin
               bt_d = '0;
               sr_d = {rxs, sr_q[9:1]};
               bc_d = bc_q + 4'd1;
               if (bc_q + 4'd1 == n_bits) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               bt_d = bt_q + 19'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.clr) begin
         rx_rdy_d = 1'b0;
         perr_d   = 1'b0;
         ferr_d   = 1'b0;
         ovf_d    = 1'b0;
      end

      // A completion in the same cycle as clr still delivers the new byte.
      if (done_q) begin
         rx_data_d = data;
         perr_d    = pen_q & (par_bit != (^data ^ ohel_q));
         ferr_d    = ~stop_bit;
         ovf_d     = bus.clr ? 1'b0 : (ovf_q | rx_rdy_q);
         rx_rdy_d  = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sync_q    <= '1;
         bt_q      <= '0;
         bc_q      <= '0;
         sr_q      <= '0;
         eight_q   <= 1'b0;
         pen_q     <= 1'b0;
         ohel_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
         rx_rdy_q  <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         bt_q      <= bt_d;
         bc_q      <= bc_d;
         sr_q      <= sr_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         ohel_q    <= ohel_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
         rx_rdy_q  <= rx_rdy_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.rx_rdy  = rx_rdy_q;
   assign bus.perr    = perr_q;
   assign bus.ferr    = ferr_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_receive_engine.sv
// Scoreboard bench for receive_engine: frames are built bit by bit, expected results
// are queued at send time and a negedge monitor checks each completed byte.
module tb_receive_engine;
   localparam int K = 15;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovf;
      int         start;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_err = 0;
   int   n_checks = 0;
   exp_t exp_q[$];

   receive_engine_if bus ();

   receive_engine #(.SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Drives start, 7/8 data bits LSB first, optional parity, stop; each bit lasts K+1 clocks.
   task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                       input logic par, input logic stp, input logic [7:0] x_data,
                       input logic x_perr, input logic x_ferr, input logic x_ovf);
      exp_t        x;
      logic [11:0] bits;
      int          nb;
      bus.eight = e;
      bus.pen   = p;
      bus.ohel  = o;
      bits      = '0;
      bits[0]   = 1'b0;
      for (int i = 0; i < 7; i++) bits[i+1] = d[i];
      nb = 8;
      if (e) begin bits[nb] = d[7]; nb++; end
      if (p) begin bits[nb] = par;  nb++; end
      bits[nb] = stp;
      nb++;
      x.data  = x_data;
      x.perr  = x_perr;
      x.ferr  = x_ferr;
      x.ovf   = x_ovf;
      x.start = cyc;
      x.lat   = 5 + K/2 + (nb - 1) * (K + 1);
      exp_q.push_back(x);
      for (int i = 0; i < nb; i++) begin
         bus.rx = bits[i];
         repeat (K + 1) @(negedge clk);
      end
      bus.rx = 1'b1;
   endtask

   task automatic do_clr(input string tag);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      check({tag, "_clr_rdy"},  bus.rx_rdy, 0);
      check({tag, "_clr_flags"}, {bus.perr, bus.ferr, bus.ovf}, 0);
   endtask

   // Monitor: a completion shows as rx_rdy rising or as new data/ovf while rx_rdy stays high.
   logic       prev_rdy  = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_ovf  = 1'b0;
   exp_t       m;
   always @(negedge clk) begin
      if (rst && bus.rx_rdy && (!prev_rdy || bus.rx_data != prev_data || bus.ovf != prev_ovf)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
         end else begin
            m = exp_q.pop_front();
            check("frame_data", bus.rx_data, m.data);
            check("frame_perr", bus.perr, m.perr);
            check("frame_ferr", bus.ferr, m.ferr);
            check("frame_ovf",  bus.ovf,  m.ovf);
            check("frame_latency", cyc - m.start, m.lat);
         end
      end
      prev_rdy  = bus.rx_rdy;
      prev_data = bus.rx_data;
      prev_ovf  = bus.ovf;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] lb_data [8] = '{8'hC3, 8'h96, 8'h7E, 8'h01, 8'hFF, 8'h80, 8'h5D, 8'h2B};

   initial begin
      logic [2:0] cfg;
      logic [7:0] d, dm;
      bus.rx = 1'b1; bus.clr = 1'b0; bus.k = 19'(K);
      bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_data", bus.rx_data, 8'h00);
      check("reset_rdy",  bus.rx_rdy, 0);
      check("reset_flags", {bus.perr, bus.ferr, bus.ovf}, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 0xA5
      send(8'hA5, 1, 0, 0, 0, 1, 8'hA5, 0, 0, 0);
      repeat (10) @(negedge clk);
      do_clr("a5");

      // 7E1 0x41 with wrong parity bit 1
      send(8'h41, 0, 1, 0, 1, 1, 8'h41, 1, 0, 0);
      repeat (10) @(negedge clk);
      check("7e1_perr_held", bus.perr, 1);
      do_clr("7e1");

      // 8O1 0x3C, correct parity 1, stop driven low
      send(8'h3C, 1, 1, 1, 1, 0, 8'h3C, 0, 1, 0);
      repeat (30) @(negedge clk);
      check("break_no_refire", exp_q.size(), 0);
      do_clr("8o1");

      // 5-clock low glitch: rejected at half bit
      bus.eight = 1'b1; bus.pen = 1'b0;
      bus.rx = 1'b0;
      repeat (5) @(negedge clk);
      bus.rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_no_rdy", bus.rx_rdy, 0);

      // Overrun: two frames without clr
      send(8'h11, 1, 0, 0, 0, 1, 8'h11, 0, 0, 0);
      send(8'h22, 1, 0, 0, 0, 1, 8'h22, 0, 0, 1);
      repeat (10) @(negedge clk);
      check("ovf_sticky", bus.ovf, 1);
      do_clr("ovf");

      // clr coincident with the second completion: completion wins, ovf cleared
      send(8'h33, 1, 0, 0, 0, 1, 8'h33, 0, 0, 0);
      fork
         send(8'h44, 1, 0, 0, 0, 1, 8'h44, 0, 0, 0);
         begin
            repeat (5 + K/2 + 9*(K+1) - 1) @(negedge clk);
            bus.clr = 1'b1;
            @(negedge clk);
            bus.clr = 1'b0;
            check("coinc_rdy", bus.rx_rdy, 1);
            check("coinc_ovf", bus.ovf, 0);
         end
      join
      repeat (10) @(negedge clk);

      // Reset during the 4th data bit of 0x77; rx_rdy/rx_data still hold 0x44
      bus.rx = 1'b0;
      repeat (K + 1) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.rx = 1'b1 ^ (i == 3);
         repeat (K + 1) @(negedge clk);
      end
      bus.rx = 1'b0;
      repeat ((K + 1) / 2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_data", bus.rx_data, 8'h00);
      check("midrst_rdy",  bus.rx_rdy, 0);
      check("midrst_flags", {bus.perr, bus.ferr, bus.ovf}, 0);
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h5A, 1, 0, 0, 0, 1, 8'h5A, 0, 0, 0);
      repeat (10) @(negedge clk);
      do_clr("post_rst");

      // Loopback of all eight/pen/ohel combinations with correct parity
      for (int c = 0; c < 8; c++) begin
         cfg = 3'(c);
         d   = lb_data[c];
         dm  = cfg[2] ? d : {1'b0, d[6:0]};
         send(d, cfg[2], cfg[1], cfg[0], ^dm ^ cfg[0], 1, dm, 0, 0, 0);
         repeat (10) @(negedge clk);
         do_clr("loopback");
      end

      repeat (20) @(negedge clk);
      check("all_frames_seen", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
